ssd_scan_controller: RTL



---
 rtl/hexaDisplay.sv | 40 ++++
 rtl/ssd_slot_timer.sv | 39 +++
 rtl/ssd_scan_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hexaDisplay.sv
// Shared types, constants and the hex-to-segment decoder for the scan controller.
package hexaDisplay;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0]      SEG_OFF = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] AN_OFF  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [SEG_W-1:0] Order(input logic [3:0] nib);
    logic [SEG_W-1:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// Per-digit slot tick counter; flags the last blank cycle and the last slot cycle.
module ssd_slot_timer #(
  parameter int unsigned DIGIT_TICKS = 100000,
  parameter int unsigned BLANK_TICKS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic blank_done_c_o,
  output logic slot_done_c_o
);

  localparam int unsigned CNT_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_TICKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count 0..DIGIT_TICKS-1 and wrap; clear holds the count at zero.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || (cnt_q == SLOT_LAST)) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign blank_done_c_o = (cnt_q == BLANK_LAST);
  assign slot_done_c_o  = (cnt_q == SLOT_LAST);

endmodule

// File: rtl/ssd_scan_controller.sv
// Multiplexed 7-segment scan controller with tear-free frame-boundary value loading.
module ssd_scan_controller
  import hexaDisplay::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned DIGIT_TICKS = 100000,
  parameter int unsigned BLANK_TICKS = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    lz_blank_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIG_W-1:0]      DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ALL   = NUM_DIGITS'(AN_OFF);

  scan_state_t state_q, state_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [VAL_W-1:0]      active_val_q, active_val_d;
  logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
  logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  pending_q, pending_d;
  logic                  load_ready_q, load_ready_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_start_q, frame_start_d;

  logic                  blank_done_c, slot_done_c;
  logic                  timer_clear_c;
  logic [NUM_DIGITS-1:0] lz_mask_c;

  assign timer_clear_c = !enable || (state_q == IDLE);

  ssd_slot_timer #(
    .DIGIT_TICKS (DIGIT_TICKS),
    .BLANK_TICKS (BLANK_TICKS)
  ) u_slot_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_i        (timer_clear_c),
    .blank_done_c_o (blank_done_c),
    .slot_done_c_o  (slot_done_c)
  );

  // Digit i is a leading zero when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    logic hi_zero;
    hi_zero   = 1'b1;
    lz_mask_c = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      hi_zero      = hi_zero & (active_val_q[4*i +: 4] == 4'h0);
      lz_mask_c[i] = hi_zero;
    end
    lz_mask_c[0] = 1'b0;
  end

  // Next state, handshake and next registered outputs.
  always_comb begin
    state_d       = state_q;
    digit_d       = digit_q;
    active_val_d  = active_val_q;
    active_dp_d   = active_dp_q;
    shadow_val_d  = shadow_val_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    an_d          = AN_ALL;
    seg_d         = SEG_OFF;
    dp_d          = 1'b1;
    frame_start_d = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      digit_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          digit_d = '0;
        end
        BLANK: begin
          if (blank_done_c) begin
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (slot_done_c) begin
            state_d = BLANK;
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          digit_d = '0;
        end
      endcase
    end

    // Entering digit-0 blank always comes from SHOW or IDLE, never from BLANK.
    frame_start_d = (state_d == BLANK) && (digit_d == '0) && (state_q != BLANK);

    // Swap in the staged value only at a frame boundary or while idle.
    if (pending_q && (frame_start_d || (state_q == IDLE))) begin
      active_val_d = shadow_val_q;
      active_dp_d  = shadow_dp_q;
      pending_d    = 1'b0;
    end

    if (load_valid && load_ready_q) begin
      shadow_val_d = value_in;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end

    if ((state_d == SHOW) && !(lz_blank_en && lz_mask_c[digit_d])) begin
      an_d  = ~(NUM_DIGITS'(1) << digit_d);
      seg_d = Order(active_val_q[4*int'(digit_d) +: 4]);
      dp_d  = ~active_dp_q[int'(digit_d)];
    end

    load_ready_d = !pending_d;
  end

  // State, data and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      digit_q       <= '0;
      active_val_q  <= '0;
      active_dp_q   <= '0;
      shadow_val_q  <= '0;
      shadow_dp_q   <= '0;
      pending_q     <= 1'b0;
      load_ready_q  <= 1'b1;
      an_q          <= AN_ALL;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      active_val_q  <= active_val_d;
      active_dp_q   <= active_dp_d;
      shadow_val_q  <= shadow_val_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      load_ready_q  <= load_ready_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign load_ready  = load_ready_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule
